// File: rtl/phasecalc_pkg.sv
// Shared types for the phase-calculation channel sequencer.
package phasecalc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/phasecalc_next_ch.sv
// Finds the lowest set mask bit strictly above i_ch (or the lowest set bit at all
// when i_from_start is high).
module phasecalc_next_ch
  import phasecalc_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] i_mask,
  input  logic [CH_W-1:0] i_ch,
  input  logic            i_from_start,
  output logic [CH_W-1:0] o_ch,
  output logic            o_found
);

  // Scanning downward leaves the lowest qualifying bit as the final assignment.
  always_comb begin
    o_ch    = '0;
    o_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_from_start || (i > int'(i_ch)))) begin
        o_ch    = CH_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phasecalc_seq.sv
// Frame sequencer: runs each channel enabled in the latched mask for RUN_LEN cycles,
// in ascending order, then pulses done; optional free-running restart.
//
//  state   | meaning
//  IDLE    | waiting for trig; all outputs low
//  RUN     | channel r_ch enabled, r_cnt counts 0..RUN_LEN-1
//  DONE    | one-cycle end of frame; done pulse, may restart in cont mode
module phasecalc_seq
  import phasecalc_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int RUN_LEN = 9,
  localparam int CH_W    = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1,
  localparam int CNT_W   = $clog2(RUN_LEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_trig,
  input  logic            i_cont_mode,
  input  logic            i_abort,
  input  logic [N_CH-1:0] i_ch_mask,
  output logic            o_start,
  output logic            o_enable,
  output logic [CH_W-1:0] o_ch_sel,
  output logic            o_busy,
  output logic            o_done
);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [CH_W-1:0]   r_ch,    w_ch_nxt;
  logic [N_CH-1:0]   r_mask,  w_mask_nxt;

  logic [CH_W-1:0]   w_first_ch, w_next_ch;
  logic              w_first_found, w_next_found;
  logic              w_last_cyc;
  logic              w_frame_go;

  phasecalc_next_ch #(.N_CH(N_CH), .CH_W(CH_W)) u_first (
    .i_mask       (i_ch_mask),
    .i_ch         ('0),
    .i_from_start (1'b1),
    .o_ch         (w_first_ch),
    .o_found      (w_first_found)
  );

  phasecalc_next_ch #(.N_CH(N_CH), .CH_W(CH_W)) u_next (
    .i_mask       (r_mask),
    .i_ch         (r_ch),
    .i_from_start (1'b0),
    .o_ch         (w_next_ch),
    .o_found      (w_next_found)
  );

  assign w_last_cyc = (r_cnt == CNT_W'(RUN_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_mask_nxt  = r_mask;
    w_frame_go  = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_frame_go = i_trig;
        ST_RUN: begin
          if (w_last_cyc) begin
            w_cnt_nxt = '0;
            if (w_next_found) w_ch_nxt    = w_next_ch;
            else              w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (i_cont_mode) w_frame_go  = 1'b1;
          else             w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      // An empty mask still produces a one-cycle DONE so the frame is acknowledged.
      if (w_frame_go) begin
        w_mask_nxt = i_ch_mask;
        w_cnt_nxt  = '0;
        if (w_first_found) begin
          w_state_nxt = ST_RUN;
          w_ch_nxt    = w_first_ch;
        end else begin
          w_state_nxt = ST_DONE;
          w_ch_nxt    = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign o_start  = (r_state == ST_RUN) && (r_cnt == '0);
  assign o_enable = (r_state == ST_RUN);
  assign o_ch_sel = (r_state == ST_IDLE) ? '0 : r_ch;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_phasecalc_seq.sv
// Bench for phasecalc_seq: frame schedule model (queue of per-cycle outputs),
// directed frame table, hand-written corner sequences and random traffic.
module tb_phasecalc_seq;

  localparam int N_CH    = 4;
  localparam int RUN_LEN = 9;
  localparam int CH_W    = 2;

  logic            clock = 1'b0;
  logic            reset, i_trig, i_cont_mode, i_abort;
  logic [N_CH-1:0] i_ch_mask;
  logic            o_start, o_enable, o_busy, o_done;
  logic [CH_W-1:0] o_ch_sel;

  phasecalc_seq #(.N_CH(N_CH), .RUN_LEN(RUN_LEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_trig      (i_trig),
    .i_cont_mode (i_cont_mode),
    .i_abort     (i_abort),
    .i_ch_mask   (i_ch_mask),
    .o_start     (o_start),
    .o_enable    (o_enable),
    .o_ch_sel    (o_ch_sel),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            s, e;
    logic [CH_W-1:0] c;
    logic            b, d;
  } outv_t;

  typedef struct {
    logic [N_CH-1:0] mask;
    int              len;
    int              nstart;
    logic [7:0]      chseq;
  } frame_vec_t;

  outv_t      cur;
  outv_t      q[$];
  int         checks = 0;
  int         errors = 0;
  frame_vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A frame is simply the list of per-cycle outputs it should produce.
  function automatic void build_frame(input logic [N_CH-1:0] m);
    int last = 0;
    q.delete();
    for (int c = 0; c < N_CH; c++) begin
      if (m[c]) begin
        for (int k = 0; k < RUN_LEN; k++)
          q.push_back('{(k == 0), 1'b1, CH_W'(c), 1'b1, 1'b0});
        last = c;
      end
    end
    q.push_back('{1'b0, 1'b0, CH_W'(last), 1'b1, 1'b1});
  endfunction

  task automatic model_edge();
    if (reset || i_abort) begin
      q.delete();
      cur = '{1'b0, 1'b0, '0, 1'b0, 1'b0};
    end else if ((!cur.b && i_trig) || (cur.d && i_cont_mode)) begin
      build_frame(i_ch_mask);
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = '{1'b0, 1'b0, '0, 1'b0, 1'b0};
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("start",  o_start,  cur.s);
    chk("enable", o_enable, cur.e);
    chk("ch_sel", o_ch_sel, cur.c);
    chk("busy",   o_busy,   cur.b);
    chk("done",   o_done,   cur.d);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {o_start, o_enable, o_ch_sel, o_busy, o_done}, 0);
  endtask

  initial begin
    int cyc, done_at, nst, nen;
    logic [7:0]  seq;
    logic [31:0] smask, dmask;

    cur = '{1'b0, 1'b0, '0, 1'b0, 1'b0};
    tbl[0] = '{4'b1111, 37, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[1] = '{4'b1010, 19, 2, {2'd0, 2'd0, 2'd3, 2'd1}};
    tbl[2] = '{4'b0000,  1, 0, 8'd0};
    tbl[3] = '{4'b0001, 10, 1, 8'd0};
    tbl[4] = '{4'b1000, 10, 1, {2'd0, 2'd0, 2'd0, 2'd3}};
    tbl[5] = '{4'b0110, 19, 2, {2'd0, 2'd0, 2'd2, 2'd1}};

    reset = 1'b1; i_trig = 1'b0; i_cont_mode = 1'b0; i_abort = 1'b0; i_ch_mask = '0;
    @(negedge clock);
    step();
    chk_all_zero("reset_state");
    reset = 1'b0;
    step();

    // Directed frames from the table.
    for (int v = 0; v < 6; v++) begin
      i_trig = 1'b1; i_ch_mask = tbl[v].mask;
      step();
      i_trig = 1'b0;
      cyc = 1; done_at = 0; nst = 0; nen = 0; seq = '0;
      while (done_at == 0 && cyc <= 60) begin
        if (o_start) begin
          if (nst < 4) seq[2*nst +: 2] = o_ch_sel;
          nst++;
        end
        if (o_enable) nen++;
        if (o_done) done_at = cyc;
        else begin
          step();
          cyc++;
        end
      end
      chk("frame_done_cycle", done_at, tbl[v].len);
      chk("frame_starts", nst, tbl[v].nstart);
      chk("frame_enable_cycles", nen, tbl[v].nstart * RUN_LEN);
      chk("frame_ch_order", seq, tbl[v].chseq);
      step();
      chk("idle_after_frame", o_busy, 0);
    end

    // Abort at T+5, retrigger at T+7.
    i_trig = 1'b1; i_ch_mask = 4'b1111;
    step();
    i_trig = 1'b0;
    repeat (4) step();
    i_abort = 1'b1;
    step();
    chk_all_zero("abort_outputs");
    i_abort = 1'b0;
    step();
    chk("abort_no_done", o_done, 0);
    i_trig = 1'b1;
    step();
    i_trig = 1'b0;
    chk("retrig_start", o_start, 1);
    chk("retrig_ch", o_ch_sel, 0);
    repeat (40) step();

    // Continuous mode, cleared at T+12.
    i_cont_mode = 1'b1; i_trig = 1'b1; i_ch_mask = 4'b0001;
    step();
    i_trig = 1'b0;
    smask = '0; dmask = '0;
    for (int c = 1; c <= 30; c++) begin
      if (o_start) smask[c] = 1'b1;
      if (o_done)  dmask[c] = 1'b1;
      if (c == 12) i_cont_mode = 1'b0;
      step();
    end
    chk("cont_starts", smask, (1 << 1) | (1 << 11));
    chk("cont_dones",  dmask, (1 << 10) | (1 << 20));
    chk("cont_ends_idle", o_busy, 0);

    // Reset mid-run.
    i_trig = 1'b1; i_ch_mask = 4'b1111;
    step();
    i_trig = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk_all_zero("reset_mid_run");
    reset = 1'b0;
    step();

    // Trig while busy and mask change mid-frame are both ignored.
    i_trig = 1'b1; i_ch_mask = 4'b1111;
    step();
    i_trig = 1'b0;
    nst = 0; done_at = 0;
    for (int c = 1; c <= 45; c++) begin
      if (o_start) nst++;
      if (o_done && done_at == 0) done_at = c;
      i_trig = (c >= 3 && c <= 5);
      if (c == 3) i_ch_mask = 4'b0001;
      step();
    end
    chk("busy_trig_starts", nst, 4);
    chk("busy_trig_done", done_at, 37);

    // Random traffic against the frame model.
    for (int n = 0; n < 3000; n++) begin
      i_trig    = ($urandom_range(0, 7) == 0);
      i_abort   = ($urandom_range(0, 96) == 0);
      reset     = ($urandom_range(0, 300) == 0);
      i_ch_mask = N_CH'($urandom);
      if ($urandom_range(0, 63) == 0) i_cont_mode = ~i_cont_mode;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
